mdu_issue_ctrl: RTL and testbench

//  Issue/stall controller for the shared multi-cycle multiply/divide unit (MDU).

---
 rtl/mdu_issue_ctrl.sv | 123 ++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mdu_issue_ctrl
// Brief   : D->X issue/stall control for the shared multi-cycle MDU; tracks
//           the single in-flight MDU destination and merges all stall sources.
// Revision: 1.0 - initial release
// ============================================================================
module mdu_issue_ctrl #(
  parameter int MDU_LAT  = 4,
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                d_valid,
  input  logic                d_is_mdu,
  input  logic                d_we,
  input  logic [4:0]          d_rs,
  input  logic [4:0]          d_rt,
  input  logic [4:0]          d_rd,
  input  logic                hz_stall,
  input  logic                br_taken,
  output logic                stall_if,
  output logic                stall_d,
  output logic                bubble_x,
  output logic                flush_d,
  output logic                mdu_start,
  output logic                mdu_wb,
  output logic [4:0]          mdu_rd,
  output logic                mdu_busy,
  output logic [STALL_CW-1:0] stall_cnt
);

  localparam int c_CNT_W = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_WB   = 2'd2;

  localparam logic [c_CNT_W-1:0]  c_CNT_LOAD = c_CNT_W'(MDU_LAT - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [STALL_CW-1:0] c_SC_ONE   = STALL_CW'(1);
  localparam logic [STALL_CW-1:0] c_SC_MAX   = '1;

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [4:0]          r_mdu_rd;
  logic [STALL_CW-1:0] r_stall_cnt;

  logic w_in_busy;
  logic w_in_wb;
  logic w_pend;
  logic w_raw;
  logic w_waw;
  logic w_struct;
  logic w_stall;
  logic w_start;
  logic w_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_start) w_next_state = c_BUSY;
      c_BUSY:  if (r_cnt == c_CNT_ONE) w_next_state = c_WB;
      c_WB:    w_next_state = w_start ? c_BUSY : c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Control outputs are gated by reset so they read 0 while it is held,
  // even if the hazard unit or branch logic is still requesting.
  always_comb begin
    w_in_busy = (r_state == c_BUSY);
    w_in_wb   = (r_state == c_WB);
    w_pend    = (w_in_busy || w_in_wb) && (r_mdu_rd != 5'd0);
    w_raw     = d_valid && w_pend && ((d_rs == r_mdu_rd) || (d_rt == r_mdu_rd));
    w_waw     = d_valid && w_pend && d_we && (d_rd == r_mdu_rd) && !d_is_mdu;
    w_struct  = d_valid && d_is_mdu && w_in_busy;
    w_stall   = !reset && !br_taken && (hz_stall || w_raw || w_waw || w_struct);
    w_start   = !reset && d_valid && d_is_mdu && !w_stall && !br_taken;
    w_flush   = !reset && br_taken;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_mdu_rd <= 5'd0;
    end else if (w_start) begin
      r_cnt    <= c_CNT_LOAD;
      r_mdu_rd <= d_rd;
    end else if (w_in_busy) begin
      r_cnt    <= r_cnt - c_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != c_SC_MAX)) begin
      r_stall_cnt <= r_stall_cnt + c_SC_ONE;
    end
  end

  assign stall_d   = w_stall;
  assign stall_if  = w_stall;
  assign bubble_x  = w_stall;
  assign flush_d   = w_flush;
  assign mdu_start = w_start;
  assign mdu_wb    = w_in_wb;
  assign mdu_busy  = w_in_busy || w_in_wb;
  assign mdu_rd    = r_mdu_rd;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdu_issue_ctrl
// Brief   : Self-checking bench for mdu_issue_ctrl using a timeline model of
//           the in-flight MDU op plus directed scenarios and random stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mdu_issue_ctrl;

  localparam int c_LAT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       d_valid = 1'b0, d_is_mdu = 1'b0, d_we = 1'b0;
  logic [4:0] d_rs = 5'd0, d_rt = 5'd0, d_rd = 5'd0;
  logic       hz_stall = 1'b0, br_taken = 1'b0;

  logic        stall_if, stall_d, bubble_x, flush_d, mdu_start, mdu_wb, mdu_busy;
  logic [4:0]  mdu_rd;
  logic [15:0] stall_cnt;

  logic        s2_if, s2_d, s2_bx, s2_fl, s2_st, s2_wb, s2_busy;
  logic [4:0]  s2_rd;
  logic [1:0]  stall_cnt2;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.MDU_LAT(c_LAT), .STALL_CW(16)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_is_mdu(d_is_mdu), .d_we(d_we),
    .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd), .hz_stall(hz_stall), .br_taken(br_taken),
    .stall_if(stall_if), .stall_d(stall_d), .bubble_x(bubble_x), .flush_d(flush_d),
    .mdu_start(mdu_start), .mdu_wb(mdu_wb), .mdu_rd(mdu_rd), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt)
  );

  mdu_issue_ctrl #(.MDU_LAT(c_LAT), .STALL_CW(2)) dut2 (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_is_mdu(d_is_mdu), .d_we(d_we),
    .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd), .hz_stall(hz_stall), .br_taken(br_taken),
    .stall_if(s2_if), .stall_d(s2_d), .bubble_x(s2_bx), .flush_d(s2_fl),
    .mdu_start(s2_st), .mdu_wb(s2_wb), .mdu_rd(s2_rd), .mdu_busy(s2_busy),
    .stall_cnt(stall_cnt2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the in-flight op is just "issued at cycle t0 to register mrd".
  bit act  = 1'b0;
  int t0   = 0;
  int mrd  = 0;
  int scnt = 0;
  int cyc  = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic step(input bit rs_t, input bit v, input bit mdu, input bit we,
                      input int rs, input int rt, input int rd,
                      input bit hz, input bit br);
    bit busy, wb, bst, pend, raw, waw, st, stall, start;
    int sc_exp, sc2_exp;
    @(negedge clk);
    reset = rs_t; d_valid = v; d_is_mdu = mdu; d_we = we;
    d_rs = rs[4:0]; d_rt = rt[4:0]; d_rd = rd[4:0]; hz_stall = hz; br_taken = br;
    #2;
    if (rs_t) begin
      busy = 0; wb = 0; stall = 0; start = 0;
      act = 0; mrd = 0; scnt = 0;
    end else begin
      busy  = act && (cyc > t0) && (cyc <= t0 + c_LAT);
      wb    = act && (cyc == t0 + c_LAT);
      bst   = busy && !wb;
      pend  = busy && (mrd != 0);
      raw   = v && pend && (rs == mrd || rt == mrd);
      waw   = v && pend && we && (rd == mrd) && !mdu;
      st    = v && mdu && bst;
      stall = !br && (hz || raw || waw || st);
      start = v && mdu && !stall && !br;
    end
    sc_exp  = (scnt > 65535) ? 65535 : scnt;
    sc2_exp = (scnt > 3) ? 3 : scnt;
    chk("stall_d",   int'(stall_d),   int'(stall));
    chk("stall_if",  int'(stall_if),  int'(stall));
    chk("bubble_x",  int'(bubble_x),  int'(stall));
    chk("flush_d",   int'(flush_d),   int'(br && !rs_t));
    chk("mdu_start", int'(mdu_start), int'(start));
    chk("mdu_wb",    int'(mdu_wb),    int'(wb));
    chk("mdu_busy",  int'(mdu_busy),  int'(busy));
    chk("mdu_rd",    int'(mdu_rd),    mrd);
    chk("stall_cnt", int'(stall_cnt), sc_exp);
    chk("stall_cnt_sat", int'(stall_cnt2), sc2_exp);
    if (!rs_t) begin
      if (stall) scnt++;
      if (start) begin
        act = 1; t0 = cyc; mrd = rd;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int pick_reg();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 8;
      2:       return 9;
      default: return int'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    int rst_left;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_busy", int'(mdu_busy), 0);
    chk("reset_stall_cnt", int'(stall_cnt), 0);

    // mul rd=8 then a dependent add
    step(0, 1, 1, 1, 1, 2, 8, 0, 0);
    chk("t1_start", int'(mdu_start), 1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, 1, 8, 3, 5, 0, 0);
      chk("t2_stall", int'(stall_d), 1);
      chk("t1_busy", int'(mdu_busy), 1);
    end
    chk("t1_wb", int'(mdu_wb), 1);
    chk("t1_rd", int'(mdu_rd), 8);
    step(0, 1, 0, 1, 8, 3, 5, 0, 0);
    chk("t2_go", int'(stall_d), 0);
    chk("t1_idle", int'(mdu_busy), 0);
    chk("t2_cnt", int'(stall_cnt), 4);

    // back-to-back muls: second issues in the WB cycle
    step(0, 1, 1, 1, 1, 2, 9, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 1, 1, 1, 2, 10, 0, 0);
      chk("t3_struct", int'(stall_d), 1);
    end
    step(0, 1, 1, 1, 1, 2, 10, 0, 0);
    chk("t3_start2", int'(mdu_start), 1);
    chk("t3_wb1", int'(mdu_wb), 1);
    chk("t3_rd1", int'(mdu_rd), 9);
    idle(3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_wb2", int'(mdu_wb), 1);
    chk("t3_rd2", int'(mdu_rd), 10);
    idle(1);

    // branch beats hz_stall and a D mul
    step(0, 1, 1, 1, 1, 2, 11, 1, 1);
    chk("t4_flush", int'(flush_d), 1);
    chk("t4_stall", int'(stall_d), 0);
    chk("t4_start", int'(mdu_start), 0);
    idle(1);
    chk("t4_state", int'(mdu_busy), 0);

    // rd=0 op never creates dependencies
    step(0, 1, 1, 1, 1, 2, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0);
    chk("t5_nostall", int'(stall_d), 0);
    chk("t5_busy", int'(mdu_busy), 1);
    idle(4);

    // reset mid-op, then counter saturation on the narrow instance
    step(0, 1, 1, 1, 1, 2, 8, 0, 0);
    idle(1);
    step(1, 1, 0, 1, 8, 8, 8, 1, 0);
    chk("t6_busy", int'(mdu_busy), 0);
    chk("t6_stall", int'(stall_d), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 2, 3, 1, 0);
    idle(1);
    chk("t6_sat", int'(stall_cnt2), 3);
    chk("t6_cnt", int'(stall_cnt), 5);

    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rst_left == 0 && $urandom_range(0, 199) == 0) rst_left = int'($urandom_range(1, 2));
      step(rst_left > 0,
           $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 70,
           pick_reg(), pick_reg(), pick_reg(),
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 8);
      if (rst_left > 0) rst_left--;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
